// File: rtl/cosim_pkg.sv
// Shared types for the co-simulation commit checker: retire record, FSM states, error codes.
package cosim_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] insn;
  } commit_t;

  typedef enum logic [1:0] {PRIME, WAIT, IDLE, HALT} state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_PC    = 2'd1,
    ERR_INSN  = 2'd2,
    ERR_PROTO = 2'd3
  } err_e;

endpackage

// File: rtl/cosim_fifo.sv
// Commit record FIFO; pointers carry one extra wrap bit to tell full from empty.
module cosim_fifo
  import cosim_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  commit_t                din,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output commit_t                head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  commit_t     mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    level    = wr_ptr_q - rd_ptr_q;
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    head     = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cosim_commit_checker.sv
// Compares buffered DUT commits against a lock-stepped reference model; sticky error on first divergence.
// Define COSIM_INSN_CHK_EN to also compare instruction encodings (otherwise pc only).
module cosim_commit_checker
  import cosim_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cm_valid,
  output logic                   cm_ready,
  input  logic [XLEN-1:0]        cm_pc,
  input  logic [ILEN-1:0]        cm_insn,
  output logic [XLEN-1:0]        ref_pc_o,
  input  logic [XLEN-1:0]        ref_npc_i,
  input  logic [ILEN-1:0]        ref_insn_i,
  input  logic                   ref_miss_i,
  output logic                   err,
  output logic [1:0]             err_code,
  output logic [XLEN-1:0]        err_dut_pc,
  output logic [XLEN-1:0]        err_ref_pc,
  output logic [ILEN-1:0]        err_dut_insn,
  output logic [CNT_W-1:0]       match_cnt,
  output logic [$clog2(DEPTH):0] level
);

`ifdef COSIM_INSN_CHK_EN
  localparam bit INSN_CHK = 1'b1;
`else
  localparam bit INSN_CHK = 1'b0;
`endif

  state_e          state_q, state_d;
  logic            step, pop, push, full, empty;
  logic            pc_eq, insn_eq, cmp_ok;
  commit_t         head, cm_rec;

  logic            err_q, err_d;
  err_e            err_code_q, err_code_d;
  logic [XLEN-1:0] err_dut_pc_q, err_dut_pc_d;
  logic [XLEN-1:0] err_ref_pc_q, err_ref_pc_d;
  logic [ILEN-1:0] err_dut_insn_q, err_dut_insn_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

  cosim_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (cm_rec),
    .full  (full),
    .empty (empty),
    .level (level),
    .head  (head)
  );

  always_comb begin
    cm_rec.pc   = cm_pc;
    cm_rec.insn = cm_insn;
    pc_eq       = (head.pc == ref_npc_i);
    insn_eq     = (head.insn == ref_insn_i);
    cmp_ok      = pc_eq && (insn_eq || !INSN_CHK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= PRIME;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PRIME:   state_d = WAIT;
      WAIT:    state_d = ref_miss_i ? HALT : IDLE;
      IDLE:    if (!empty) state_d = cmp_ok ? WAIT : HALT;
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  // Holding ref_pc_o at ~ref_npc_i is what keeps the reference from advancing.
  always_comb begin
    pop      = (state_q == IDLE) && !empty && cmp_ok;
    step     = (state_q == PRIME) || pop;
    cm_ready = rst_n && !full && (state_q != HALT);
    push     = cm_valid && cm_ready;
    ref_pc_o = step ? ref_npc_i : ~ref_npc_i;
  end

  always_comb begin
    err_d          = err_q;
    err_code_d     = err_code_q;
    err_dut_pc_d   = err_dut_pc_q;
    err_ref_pc_d   = err_ref_pc_q;
    err_dut_insn_d = err_dut_insn_q;
    match_cnt_d    = match_cnt_q + CNT_W'(pop);
    if ((state_q != HALT) && (state_d == HALT)) begin
      err_d          = 1'b1;
      err_code_d     = (state_q == WAIT) ? ERR_PROTO : (!pc_eq ? ERR_PC : ERR_INSN);
      err_dut_pc_d   = head.pc;
      err_ref_pc_d   = ref_npc_i;
      err_dut_insn_d = head.insn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q          <= 1'b0;
      err_code_q     <= ERR_NONE;
      err_dut_pc_q   <= '0;
      err_ref_pc_q   <= '0;
      err_dut_insn_q <= '0;
      match_cnt_q    <= '0;
    end else begin
      err_q          <= err_d;
      err_code_q     <= err_code_d;
      err_dut_pc_q   <= err_dut_pc_d;
      err_ref_pc_q   <= err_ref_pc_d;
      err_dut_insn_q <= err_dut_insn_d;
      match_cnt_q    <= match_cnt_d;
    end
  end

  assign err          = err_q;
  assign err_code     = err_code_q;
  assign err_dut_pc   = err_dut_pc_q;
  assign err_ref_pc   = err_ref_pc_q;
  assign err_dut_insn = err_dut_insn_q;
  assign match_cnt    = match_cnt_q;

endmodule
